// File: rtl/raster_timing_pkg.sv
// Shared raster presets and the span decode used by the timing counter.
//   VGA_*  : 640x480@60 timing, active-low syncs.
//   TST_*  : tiny 4x3 raster used for quick simulation.
package raster_timing_pkg;

    // 640x480@60
    localparam int   VGA_WIDTH    = 800;
    localparam int   VGA_HEIGHT   = 525;
    localparam int   VGA_H_ACTIVE = 640;
    localparam int   VGA_HS_START = 656;
    localparam int   VGA_HS_END   = 752;
    localparam int   VGA_V_ACTIVE = 480;
    localparam int   VGA_VS_START = 490;
    localparam int   VGA_VS_END   = 492;
    localparam logic VGA_HS_POL   = 1'b0;
    localparam logic VGA_VS_POL   = 1'b0;

    // Small test raster
    localparam int   TST_WIDTH    = 4;
    localparam int   TST_HEIGHT   = 3;
    localparam int   TST_H_ACTIVE = 2;
    localparam int   TST_HS_START = 2;
    localparam int   TST_HS_END   = 3;
    localparam int   TST_V_ACTIVE = 2;
    localparam int   TST_VS_START = 2;
    localparam int   TST_VS_END   = 3;
    localparam logic TST_HS_POL   = 1'b1;
    localparam logic TST_VS_POL   = 1'b1;

    // Half-open span test: lo <= v < hi
    function automatic logic in_span(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/raster_timing_counter_wrap_counter.sv
// Wrapping counter 0..MAX with a registered terminal-count flag.
//   clk    : clock
//   reset  : synchronous active-high reset to 0
//   en     : advance by one (wraps MAX -> 0)
//   clr    : synchronous clear to 0, independent of en
//   count  : current value
//   at_max : 1 when count == MAX (registered alongside count)
module wrap_counter #(
    parameter int BITS = 10,
    parameter int MAX  = 799
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            clr,
    output logic [BITS-1:0] count,
    output logic            at_max
);

    localparam logic [BITS-1:0] MAX_V = BITS'(MAX);

    logic [BITS-1:0] count_q, count_d;
    logic            at_max_q;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en)
            count_d = (count_q == MAX_V) ? '0 : count_q + BITS'(1);
    end

    // The flag is decoded from the next count so it never lags count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            at_max_q <= (MAX == 0);
        end else begin
            count_q  <= count_d;
            at_max_q <= (count_d == MAX_V);
        end
    end

    assign count  = count_q;
    assign at_max = at_max_q;

endmodule

// File: rtl/raster_timing_counter.sv
// Raster walker: x/y over active + blanking with registered sync/active/
// boundary outputs that always describe the (x,y) presented alongside them.
//   clk, reset : pixel clock, synchronous active-high reset
//   on         : advance enable; 0 holds every output
//   restart    : reload (0,0) when on=1
//   x, y       : current column / line
//   hsync/vsync: syncs with polarity HS_POL / VS_POL
//   active     : x < H_ACTIVE and y < V_ACTIVE
//   line_end   : x == WIDTH-1
//   frame_end  : x == WIDTH-1 and y == HEIGHT-1
module raster_timing_counter
    import raster_timing_pkg::*;
#(
    parameter int   XBITS    = 10,
    parameter int   YBITS    = 10,
    parameter int   WIDTH    = VGA_WIDTH,
    parameter int   HEIGHT   = VGA_HEIGHT,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   HS_START = VGA_HS_START,
    parameter int   HS_END   = VGA_HS_END,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   VS_START = VGA_VS_START,
    parameter int   VS_END   = VGA_VS_END,
    parameter logic HS_POL   = VGA_HS_POL,
    parameter logic VS_POL   = VGA_VS_POL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             on,
    input  logic             restart,
    output logic [XBITS-1:0] x,
    output logic [YBITS-1:0] y,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             line_end,
    output logic             frame_end
);

    generate
        if (WIDTH > 2**XBITS || HEIGHT > 2**YBITS) begin : g_bad_size
            $error("raster_timing_counter: WIDTH/HEIGHT exceed counter width");
        end
        if (!(H_ACTIVE <= HS_START && HS_START <= HS_END && HS_END <= WIDTH)) begin : g_bad_h
            $error("raster_timing_counter: horizontal timing out of order");
        end
        if (!(V_ACTIVE <= VS_START && VS_START <= VS_END && VS_END <= HEIGHT)) begin : g_bad_v
            $error("raster_timing_counter: vertical timing out of order");
        end
    endgenerate

    logic x_at_max, y_at_max;
    logic clr;

    // restart only counts when enabled
    assign clr = on & restart;

    wrap_counter #(.BITS(XBITS), .MAX(WIDTH-1)) u_x (
        .clk(clk), .reset(reset), .en(on), .clr(clr),
        .count(x), .at_max(x_at_max)
    );

    wrap_counter #(.BITS(YBITS), .MAX(HEIGHT-1)) u_y (
        .clk(clk), .reset(reset), .en(on & x_at_max), .clr(clr),
        .count(y), .at_max(y_at_max)
    );

    // Position the counters will hold after a normal advance; the decodes
    // are taken from it so they land in the same cycle as x/y.
    int x_nxt, y_nxt;
    always_comb begin
        x_nxt = x_at_max ? 0 : int'(x) + 1;
        y_nxt = int'(y);
        if (x_at_max)
            y_nxt = y_at_max ? 0 : int'(y) + 1;
    end

    logic hsync_q, vsync_q, active_q, frame_end_q;
    logic hsync_d, vsync_d, active_d, frame_end_d;

    always_comb begin
        hsync_d     = in_span(x_nxt, HS_START, HS_END) ? HS_POL : ~HS_POL;
        vsync_d     = in_span(y_nxt, VS_START, VS_END) ? VS_POL : ~VS_POL;
        active_d    = (x_nxt < H_ACTIVE) && (y_nxt < V_ACTIVE);
        frame_end_d = (x_nxt == WIDTH-1) && (y_nxt == HEIGHT-1);
    end

    // Reset and restart load the same fixed (0,0) decode.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hsync_q     <= ~HS_POL;
            vsync_q     <= ~VS_POL;
            active_q    <= 1'b1;
            frame_end_q <= (WIDTH == 1) && (HEIGHT == 1);
        end else if (on) begin
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            active_q    <= active_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign active    = active_q;
    assign line_end  = x_at_max;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_raster_timing_counter.sv
// Scoreboard bench on the small 4x3 raster: every stimulus cycle pushes the
// reference model's expected outputs; a monitor pops and compares each cycle.
module tb_raster_timing_counter;
    localparam int   W = 4, H = 3, HA = 2, HSS = 2, HSE = 3;
    localparam int   VA = 2, VSS = 2, VSE = 3;
    localparam logic HP = 1'b1, VP = 1'b1;

    logic clk = 1'b0, reset = 1'b0, on = 1'b0, restart = 1'b0;
    logic [9:0] x, y;
    logic hsync, vsync, active, line_end, frame_end;

    raster_timing_counter #(
        .XBITS(10), .YBITS(10), .WIDTH(W), .HEIGHT(H), .H_ACTIVE(HA),
        .HS_START(HSS), .HS_END(HSE), .V_ACTIVE(VA), .VS_START(VSS),
        .VS_END(VSE), .HS_POL(HP), .VS_POL(VP)
    ) dut (
        .clk(clk), .reset(reset), .on(on), .restart(restart),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync), .active(active),
        .line_end(line_end), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic hs, vs, act, le, fe;
    } obs_t;

    obs_t exp_q[$];
    int errors = 0, checks = 0;
    int mx = 0, my = 0;

    function automatic obs_t model_out(input int ax, input int ay);
        obs_t o;
        o.x   = 10'(ax);
        o.y   = 10'(ay);
        o.hs  = (ax >= HSS && ax < HSE) ? HP : ~HP;
        o.vs  = (ay >= VSS && ay < VSE) ? VP : ~VP;
        o.act = (ax < HA) && (ay < VA);
        o.le  = (ax == W-1);
        o.fe  = (ax == W-1) && (ay == H-1);
        return o;
    endfunction

    // One clock of stimulus; the model position is updated from the rules
    // and the expected outputs for that position are queued.
    task automatic step(input logic r, input logic o, input logic rs);
        @(negedge clk);
        reset = r; on = o; restart = rs;
        @(posedge clk);
        if (r) begin
            mx = 0; my = 0;
        end else if (o) begin
            if (rs) begin
                mx = 0; my = 0;
            end else begin
                mx = (mx + 1) % W;
                if (mx == 0) my = (my + 1) % H;
            end
        end
        exp_q.push_back(model_out(mx, my));
    endtask

    initial begin : monitor
        obs_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                g = '{x, y, hsync, vsync, active, line_end, frame_end};
                checks++;
                if (g !== e)
                begin
                    errors++;
                    $display("FAIL outputs t=%0t got x=%0d y=%0d hs=%b vs=%b act=%b le=%b fe=%b exp x=%0d y=%0d hs=%b vs=%b act=%b le=%b fe=%b",
                             $time, g.x, g.y, g.hs, g.vs, g.act, g.le, g.fe,
                             e.x, e.y, e.hs, e.vs, e.act, e.le, e.fe);
                end
            end
        end
    end

    initial begin : stim
        // reset and hold
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        // full frame plus wrap
        repeat (12) step(1'b0, 1'b1, 1'b0);
        // gated enable, crossing the (3,2) -> (0,0) boundary
        for (int i = 0; i < 24; i++) step(1'b0, (i % 2) == 0, 1'b0);
        // restart at (2,1), then restart while disabled
        for (int i = 0; i < 20 && !(mx == 2 && my == 1); i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        // reset beats restart at (3,2)
        for (int i = 0; i < 20 && !(mx == 3 && my == 2); i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        // random mix
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0);
        // let the monitor drain, bounded
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
